// File: rtl/router_pkg.sv
// Shared router definitions: default port sizing and index/credit types.
package router_pkg;

  localparam int unsigned DEF_NUM_VC    = 4;
  localparam int unsigned DEF_BUF_DEPTH = 4;
  localparam int unsigned DEF_VCW       = $clog2(DEF_NUM_VC);
  localparam int unsigned DEF_CREDW     = $clog2(DEF_BUF_DEPTH + 1);

  typedef logic [DEF_VCW-1:0]   vc_id_t;
  typedef logic [DEF_CREDW-1:0] credit_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] eligible,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] winner,
  output logic [W-1:0] winner_idx,
  output logic         any_valid
);

  int unsigned cand;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    any_valid  = 1'b0;
    cand       = 0;
    for (int unsigned off = 0; off < N; off++) begin
      cand = (32'(ptr) + off) % N;
      if (!any_valid && eligible[cand]) begin
        any_valid      = 1'b1;
        winner[cand]   = 1'b1;
        winner_idx     = W'(cand);
      end
    end
  end

endmodule

// File: rtl/vc_credit_arbiter.sv
// Per-output-port VC scheduler: round-robin among credited requesters,
// registered grant, per-VC downstream credit counters with sticky overflow.
module vc_credit_arbiter
  import router_pkg::*;
#(
  parameter int unsigned NUM_VC    = DEF_NUM_VC,
  parameter int unsigned BUF_DEPTH = DEF_BUF_DEPTH,
  parameter int unsigned VCW       = $clog2(NUM_VC),
  parameter int unsigned CREDW     = $clog2(BUF_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_VC-1:0] req,
  input  logic              stall,
  input  logic              credit_in_valid,
  input  logic [VCW-1:0]    credit_in_vc,
  output logic [NUM_VC-1:0] grant,
  output logic              grant_valid,
  output logic [VCW-1:0]    grant_vc,
  output logic              pipe_enable,
  output logic [NUM_VC-1:0] credit_avail,
  output logic              credit_overflow
);

  logic [NUM_VC-1:0][CREDW-1:0] credits, credits_nxt;
  logic [VCW-1:0]               rr_ptr, rr_ptr_nxt;
  logic [NUM_VC-1:0]            eligible, win_onehot;
  logic [VCW-1:0]               win_idx;
  logic                         win_any, consume, ovf_nxt, ret, cons;

  always_comb begin
    credit_avail = '0;
    for (int unsigned i = 0; i < NUM_VC; i++)
      credit_avail[i] = (credits[i] != '0);
  end

  assign eligible    = req & credit_avail;
  assign pipe_enable = ~stall;
  assign consume     = ~stall & win_any;

  rr_arbiter #(.N(NUM_VC), .W(VCW)) u_rr (
    .eligible   (eligible),
    .ptr        (rr_ptr),
    .winner     (win_onehot),
    .winner_idx (win_idx),
    .any_valid  (win_any)
  );

  assign rr_ptr_nxt = (win_idx == VCW'(NUM_VC - 1)) ? '0 : win_idx + VCW'(1);

  // Out-of-range credit_in_vc matches no counter, so the return is dropped.
  always_comb begin
    credits_nxt = credits;
    ovf_nxt     = credit_overflow;
    ret         = 1'b0;
    cons        = 1'b0;
    for (int unsigned i = 0; i < NUM_VC; i++) begin
      ret  = credit_in_valid && (32'(credit_in_vc) == i);
      cons = consume && win_onehot[i];
      if (ret && !cons) begin
        if (credits[i] == CREDW'(BUF_DEPTH)) ovf_nxt = 1'b1;
        else                                 credits_nxt[i] = credits[i] + CREDW'(1);
      end else if (cons && !ret) begin
        credits_nxt[i] = credits[i] - CREDW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      credits         <= {NUM_VC{CREDW'(BUF_DEPTH)}};
      rr_ptr          <= '0;
      grant           <= '0;
      grant_valid     <= 1'b0;
      grant_vc        <= '0;
      credit_overflow <= 1'b0;
    end else begin
      credits         <= credits_nxt;
      credit_overflow <= ovf_nxt;
      if (!stall) begin
        grant       <= win_onehot;
        grant_valid <= win_any;
        grant_vc    <= win_idx;
        if (win_any) rr_ptr <= rr_ptr_nxt;
      end
    end
  end

endmodule
